// File: rtl/semaforo_pkg.sv
// Shared encodings and default timing for the traffic-light event generator.
// Lamp codes match the light FSM; monitor states reuse them plus a fault code.
package semaforo_pkg;

   localparam logic [1:0] S_GRN = 2'b00;
   localparam logic [1:0] S_YLW = 2'b01;
   localparam logic [1:0] S_RED = 2'b10;

   localparam logic [1:0] M_GRN   = S_GRN;
   localparam logic [1:0] M_YLW   = S_YLW;
   localparam logic [1:0] M_RED   = S_RED;
   localparam logic [1:0] M_FAULT = 2'b11;

   localparam int DEF_DEB_CYCLES = 4;
   localparam int DEF_MIN_GRN    = 8;
   localparam int DEF_RED_CYCLES = 10;
   localparam int DEF_CNT_W      = 8;

   typedef struct packed {
      logic grn;
      logic ylw;
      logic red;
   } lamps_t;

   // Any pattern that is not exactly one lamp classifies as a fault.
   function automatic logic [1:0] lamp_class(lamps_t l);
      case ({l.grn, l.ylw, l.red})
         3'b100:  lamp_class = M_GRN;
         3'b010:  lamp_class = M_YLW;
         3'b001:  lamp_class = M_RED;
         default: lamp_class = M_FAULT;
      endcase
   endfunction

endpackage

// File: rtl/semaforo_event_gen_if.sv
// Signals exchanged between the event generator and the traffic-light FSM side.
interface semaforo_event_gen_if;
   logic car_raw;
   logic GRN;
   logic YLW;
   logic RED;
   logic CAR;
   logic TIMEOUT;
   logic FAULT;

   modport slave (
      input  car_raw, GRN, YLW, RED,
      output CAR, TIMEOUT, FAULT
   );

   modport master (
      output car_raw, GRN, YLW, RED,
      input  CAR, TIMEOUT, FAULT
   );
endinterface

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a debouncer: the output flips only after
// DEB_CYCLES consecutive synchronized samples disagree with it.
module debounce_sync #(
   parameter int DEB_CYCLES = 4,
   parameter int CNT_W      = 8
) (
   input  logic clk,
   input  logic res,
   input  logic din,
   output logic dout
);

   logic             r_s1;
   logic             r_s2;
   logic             r_db_state;
   logic [CNT_W-1:0] r_deb_cnt;

   always_ff @(posedge clk) begin
      if (!res) begin
         r_s1       <= 1'b0;
         r_s2       <= 1'b0;
         r_db_state <= 1'b0;
         r_deb_cnt  <= '0;
      end else begin
         r_s1 <= din;
         r_s2 <= r_s1;
         if (r_s2 != r_db_state) begin
            if (r_deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
               r_db_state <= ~r_db_state;
               r_deb_cnt  <= '0;
            end else begin
               r_deb_cnt <= r_deb_cnt + 1'b1;
            end
         end else begin
            r_deb_cnt <= '0;
         end
      end
   end

   assign dout = r_db_state;

endmodule

// File: rtl/semaforo_event_gen.sv
// Drives CAR/TIMEOUT into the traffic-light FSM and flags lamp patterns
// that are not one-hot.
module semaforo_event_gen
   import semaforo_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int MIN_GRN    = DEF_MIN_GRN,
   parameter int RED_CYCLES = DEF_RED_CYCLES,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 res,
   semaforo_event_gen_if.slave  bus
);

   logic             w_db_state;
   lamps_t           w_lamps;
   logic [1:0]       w_lamp_cls;
   logic             w_onehot;
   logic             w_grn1h;
   logic             w_red1h;
   logic [1:0]       w_mstate_next;

   logic             r_db_prev;
   logic             r_car_req;
   logic [1:0]       r_mstate;
   logic [CNT_W-1:0] r_grn_cnt;
   logic [CNT_W-1:0] r_red_cnt;
   logic             r_car;
   logic             r_timeout;
   logic             r_fault;

   debounce_sync #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
   ) u_deb (
      .clk  (clk),
      .res  (res),
      .din  (bus.car_raw),
      .dout (w_db_state)
   );

   assign w_lamps    = '{grn: bus.GRN, ylw: bus.YLW, red: bus.RED};
   assign w_lamp_cls = lamp_class(w_lamps);
   assign w_onehot   = (w_lamp_cls != M_FAULT);
   assign w_grn1h    = (w_lamp_cls == M_GRN);
   assign w_red1h    = (w_lamp_cls == M_RED);

   // Fault is sticky until a clean green is seen.
   always_comb begin
      w_mstate_next = w_lamp_cls;
      if (!w_grn1h && r_mstate == M_FAULT)
         w_mstate_next = M_FAULT;
   end

   always_ff @(posedge clk) begin
      if (!res) begin
         r_db_prev <= 1'b0;
         r_car_req <= 1'b0;
         r_mstate  <= M_GRN;
         r_grn_cnt <= '0;
         r_red_cnt <= '0;
         r_car     <= 1'b0;
         r_timeout <= 1'b0;
         r_fault   <= 1'b0;
      end else begin
         r_db_prev <= w_db_state;
         r_mstate  <= w_mstate_next;

         if (bus.YLW)
            r_car_req <= 1'b0;
         else if (w_db_state && !r_db_prev)
            r_car_req <= 1'b1;

         if (!w_grn1h)
            r_grn_cnt <= '0;
         else if (w_mstate_next == M_GRN && r_grn_cnt < CNT_W'(MIN_GRN))
            r_grn_cnt <= r_grn_cnt + 1'b1;

         if (!w_red1h)
            r_red_cnt <= '0;
         else if (r_red_cnt < CNT_W'(RED_CYCLES))
            r_red_cnt <= r_red_cnt + 1'b1;

         r_car     <= r_car_req & w_grn1h & (r_grn_cnt >= CNT_W'(MIN_GRN));
         r_timeout <= w_red1h & (r_red_cnt >= CNT_W'(RED_CYCLES - 1));
         r_fault   <= ~w_onehot;
      end
   end

   assign bus.CAR     = r_car;
   assign bus.TIMEOUT = r_timeout;
   assign bus.FAULT   = r_fault;

endmodule

// File: tb/tb_semaforo_event_gen.sv
// Directed scenarios plus randomized lamp/sensor traffic, checked every edge
// against a run-length / sample-history reference model.
module tb_semaforo_event_gen;
   import semaforo_pkg::*;

   localparam int DEB  = 4;
   localparam int MING = 8;
   localparam int REDC = 10;

   logic clk = 1'b0;
   logic res;
   semaforo_event_gen_if bus();

   semaforo_event_gen #(
      .DEB_CYCLES (DEB),
      .MIN_GRN    (MING),
      .RED_CYCLES (REDC),
      .CNT_W      (8)
   ) dut (
      .clk (clk),
      .res (res),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   bit raw_q[$];
   bit obs_hist[$];
   bit m_db, m_db_prev, m_req, m_car, m_to, m_fault;
   int grn_run, red_run;

   task automatic chk(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0b expected %0b at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      raw_q = {};
      raw_q.push_back(1'b0);
      raw_q.push_back(1'b0);
      obs_hist = {};
      for (int i = 0; i < DEB; i++) obs_hist.push_back(1'b0);
      m_db = 0; m_db_prev = 0; m_req = 0;
      m_car = 0; m_to = 0; m_fault = 0;
      grn_run = 0; red_run = 0;
   endtask

   task automatic model_edge();
      bit g1, y1, r1, obs, all_diff, n_req;
      if (!res) begin
         model_reset();
      end else begin
         g1 = bus.GRN & ~bus.YLW & ~bus.RED;
         y1 = ~bus.GRN & bus.YLW & ~bus.RED;
         r1 = ~bus.GRN & ~bus.YLW & bus.RED;
         m_car   = m_req & g1 & (grn_run >= MING);
         m_to    = r1 & ((red_run + 1) >= REDC);
         m_fault = ~(g1 | y1 | r1);
         n_req   = (m_req | (m_db & ~m_db_prev)) & ~bus.YLW;
         m_req   = n_req;
         m_db_prev = m_db;
         // sensor value seen by the debouncer is two edges old
         obs = raw_q.pop_front();
         raw_q.push_back(bus.car_raw);
         void'(obs_hist.pop_front());
         obs_hist.push_back(obs);
         all_diff = 1;
         foreach (obs_hist[i]) if (obs_hist[i] == m_db) all_diff = 0;
         if (all_diff) m_db = ~m_db;
         grn_run = g1 ? ((grn_run < 1000) ? grn_run + 1 : grn_run) : 0;
         red_run = r1 ? ((red_run < 1000) ? red_run + 1 : red_run) : 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("CAR", bus.CAR, m_car);
      chk("TIMEOUT", bus.TIMEOUT, m_to);
      chk("FAULT", bus.FAULT, m_fault);
   endtask

   task automatic lamps(input logic g, input logic y, input logic r);
      bus.GRN = g; bus.YLW = y; bus.RED = r;
   endtask

   initial begin
      int ph_len;
      int seq;
      logic [2:0] pat;
      model_reset();
      res = 1'b0;
      bus.car_raw = 1'b1;
      lamps(0, 0, 1);

      // Reset with sensor high and red lit
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_CAR", bus.CAR, 1'b0);
         chk("rst_TIMEOUT", bus.TIMEOUT, 1'b0);
         chk("rst_FAULT", bus.FAULT, 1'b0);
      end
      bus.car_raw = 1'b0;
      res = 1'b1;
      for (int i = 1; i <= REDC; i++) begin
         tick();
         chk("post_rst_timeout", bus.TIMEOUT, (i == REDC) ? 1'b1 : 1'b0);
      end
      $display("scenario reset: done");

      // Long green, then a clean car arrival
      lamps(1, 0, 0);
      repeat (12) tick();
      bus.car_raw = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         tick();
         chk("car_latency", bus.CAR, (i >= 7) ? 1'b1 : 1'b0);
      end
      lamps(0, 1, 0);
      tick();
      chk("car_drop_ylw", bus.CAR, 1'b0);
      bus.car_raw = 1'b0;
      repeat (3) tick();
      lamps(1, 0, 0);
      repeat (12) tick();
      $display("scenario car on green: done");

      // Short glitch on the sensor
      bus.car_raw = 1'b1;
      repeat (3) tick();
      bus.car_raw = 1'b0;
      for (int i = 0; i < 14; i++) begin
         tick();
         chk("glitch_no_car", bus.CAR, 1'b0);
      end
      $display("scenario glitch: done");

      // Red timeout and release
      lamps(0, 0, 1);
      for (int i = 1; i <= REDC; i++) begin
         tick();
         chk("red_timeout", bus.TIMEOUT, (i == REDC) ? 1'b1 : 1'b0);
      end
      lamps(1, 0, 0);
      tick();
      chk("timeout_fall", bus.TIMEOUT, 1'b0);
      $display("scenario red timeout: done");

      // Car queued during red, served after minimum green
      lamps(0, 0, 1);
      bus.car_raw = 1'b1;
      repeat (6) tick();
      bus.car_raw = 1'b0;
      repeat (8) tick();
      lamps(1, 0, 0);
      for (int g = 1; g <= 12; g++) begin
         tick();
         chk("queued_car", bus.CAR, (g >= MING + 1) ? 1'b1 : 1'b0);
      end
      lamps(0, 1, 0);
      repeat (2) tick();
      $display("scenario queued car: done");

      // Lamp fault, recovery, then reset in the middle of red
      lamps(1, 0, 1);
      tick();
      chk("fault_set", bus.FAULT, 1'b1);
      chk("fault_car", bus.CAR, 1'b0);
      chk("fault_timeout", bus.TIMEOUT, 1'b0);
      lamps(1, 0, 0);
      tick();
      chk("fault_clear", bus.FAULT, 1'b0);
      lamps(0, 0, 1);
      repeat (5) tick();
      res = 1'b0;
      tick();
      res = 1'b1;
      for (int i = 1; i <= REDC; i++) begin
         tick();
         chk("midred_reset", bus.TIMEOUT, (i == REDC) ? 1'b1 : 1'b0);
      end
      $display("scenario fault and mid-red reset: done");

      // Randomized traffic
      ph_len = 0;
      seq = 0;
      pat = 3'b100;
      repeat (3000) begin
         if (ph_len == 0) begin
            if ($urandom_range(0, 9) == 0) begin
               pat = 3'($urandom_range(0, 7));
               ph_len = int'($urandom_range(1, 3));
            end else begin
               seq = (seq + 1) % 3;
               pat = (seq == 0) ? 3'b100 : (seq == 1) ? 3'b010 : 3'b001;
               ph_len = (seq == 0) ? int'($urandom_range(1, 20)) :
                        (seq == 1) ? int'($urandom_range(1, 4)) :
                                     int'($urandom_range(1, 14));
            end
            $display("random phase lamps=%b len=%0d", pat, ph_len);
         end
         {bus.GRN, bus.YLW, bus.RED} = pat;
         ph_len--;
         if ($urandom_range(0, 5) == 0) bus.car_raw = ~bus.car_raw;
         res = ($urandom_range(0, 399) != 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
